feature_mem_arbiter: RTL and testbench
======================================

# feature_mem_arbiter

Arbitrates the single-port feature memory (features, instructions, conv results) between three requesters inside the CNN accelerator: instruction fetch, PE operand read and PE result write-back. It has a round-robin grant policy with optional bounded burst locking. It drives the existing `feature_addr` / `feature_data` / `feature_mem_en` / `feature_idata` memory interface, so the external memory model is unchanged, and returns read data to the requesting port.

## Interface
Parameters:
- `ADDR_W`, 12, feature memory address width
- `DATA_W`, 32, data word width
- `N_REQ`, 3, requester count; port 0 = instruction fetch, 1 = PE read, 2 = PE write-back
- `MAX_LOCK`, 16, maximum consecutive locked grants before the lock is forcibly broken

Ports:
- `clk`  in  1  single clock; all logic on posedge
- `reset`  in  1  synchronous, active-high
- `req`  in  N_REQ  per-port request; held with its payload until granted
- `we`  in  N_REQ  per-port write (1) / read (0)
- `lock`  in  N_REQ  per-port request to keep ownership for the next beat
- `addr`  in  N_REQ*ADDR_W  packed per-port addresses; port i is at [i*ADDR_W +: ADDR_W]
- `wdata`  in  N_REQ*DATA_W  packed per-port write data
- `gnt`  out  N_REQ  one-hot grant, combinational; the beat is accepted at the posedge where req[i]&gnt[i]
- `rvalid`  out  N_REQ  one-cycle pulse marking read data for port i
- `rdata`  out  DATA_W  registered read data, shared by all ports and qualified by rvalid
- `feature_addr`  out  ADDR_W  registered memory address
- `feature_data`  out  DATA_W  registered memory write data
- `feature_mem_en`  out  1  registered write enable; the memory writes on the posedge while it is high
- `feature_idata`  in  DATA_W  memory read data, valid before the posedge that ends the cycle feature_addr is driven

## Operation
- Round-robin: the priority search starts at `last+1` mod N_REQ, where `last` is the most recently accepted port.
- `gnt` is zero when `req` is zero. At most one `gnt` bit is high.
- Lock: a beat accepted with `lock[i]=1` sets `owner=i`. While the owner is set, only the owner can be granted.
  - If the owner drops `req`, the lock releases and normal round-robin resumes in the same cycle.
  - A beat accepted with `lock=0` releases ownership.
- Lock limit: `lock_cnt` counts consecutive locked acceptances. On reaching MAX_LOCK, ownership clears and the accepting port becomes `last`. The next arbitration is then round-robin, so any other requester gets priority.
- On an accepted write: `feature_addr<=addr[i]`, `feature_data<=wdata[i]`, `feature_mem_en<=1`.
- On an accepted read: `feature_addr<=addr[i]`, `feature_mem_en<=0`, and a tag `{valid, port}` is pushed into a 2-stage pipe.
- When the tag reaches stage 2: `rdata<=feature_idata` (registered in the cycle after accept), then `rvalid[port]` pulses.
- With no acceptance: `feature_mem_en<=0`; `feature_addr` and `feature_data` hold.
- Read-after-write to the same address on consecutive beats returns the new data, because the memory write completes before the following read's address cycle.

## Timing
- Cycle N: req/gnt high, acceptance at the end of N.
- Cycle N+1: feature_addr and feature_mem_en are valid; a write commits at the end of N+1.
- Read: rvalid[i] and rdata are valid in cycle N+2, giving a read latency of 2.
- Throughput: one beat per cycle, with reads and writes interleaved freely. Multiple reads may be in flight and are returned in order.
- Reset values: gnt=0, rvalid=0, rdata=0, feature_addr=0, feature_data=0, feature_mem_en=0, last=N_REQ-1 (port 0 has first priority), owner=none, lock_cnt=0, tag pipe cleared.
- Reset mid-operation: in-flight reads are discarded (no rvalid) and a pending write is not issued. `gnt` is 0 while reset is high.
- Simultaneous events:
  - Lock release and a new request arriving in the same cycle resolve by round-robin.
  - `req` dropping on the same edge as `gnt` is not an acceptance.

## Structure
- Shared package `cnn_mem_pkg`: ADDR_W, DATA_W, N_REQ, and port-index constants PORT_IFETCH=0, PORT_PE_RD=1, PORT_PE_WB=2.
- Sub-module `rr_arbiter`: a combinational rotate-priority one-hot picker with inputs (req_masked, last) and output gnt.
- Lock, counter, memory-port registers and the tag pipe stay in the top module.

## Test plan
- Port 0 reads addr 0x010 where memory holds 0xDEADBEEF → gnt[0] in cycle 0; feature_addr=0x010 in cycle 1; rvalid[0]=1 and rdata=0xDEADBEEF in cycle 2 only.
- All three ports request reads continuously with lock=0 → acceptance order 0,1,2,0,1,2; each rvalid is returned in order, 2 cycles after its acceptance.
- Port 2 writes 0x12345678 to addr 5, then port 1 reads addr 5 on the next cycle → feature_mem_en=1 for exactly one cycle; rdata=0x12345678 with rvalid[1].
- Port 1 requests with lock=1 continuously while port 0 also requests → port 1 is granted 16 consecutive times, then port 0 once, then port 1 again.
- Reset asserted in the cycle after a read is accepted → no rvalid pulse, and all outputs are at their reset values on the next cycle. Afterwards, port 0 wins the first arbitration when all ports request.
- Locked port 1 drops req with port 2 requesting → gnt[2] is asserted in the same cycle.

Source files
------------

// File: rtl/cnn_mem_pkg.sv
// Shared constants for the CNN accelerator feature-memory path.
// Port indices name the fixed requester order seen by the arbiter.
package cnn_mem_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int N_REQ  = 3;

  localparam int PORT_IFETCH = 0;
  localparam int PORT_PE_RD  = 1;
  localparam int PORT_PE_WB  = 2;

  // Width of a port index; never collapses to zero for a single requester.
  function automatic int port_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority picker: the search starts one past 'last'
// and the first requesting port in that circular order wins (one-hot).
module rr_arbiter
  import cnn_mem_pkg::*;
#(
  parameter int NUM_REQ = N_REQ,
  parameter int IDX_W   = port_w(N_REQ)
) (
  input  logic [NUM_REQ-1:0] req_masked,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] gnt
);

  int idx;

  // Walk from the farthest candidate to the nearest so the nearest overrides.
  always_comb begin
    gnt = '0;
    idx = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (req_masked[idx]) begin
        gnt = '0;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/feature_mem_arbiter.sv
// Single-port feature memory arbiter: round-robin grant with bounded burst
// locking, registered memory interface and a 2-stage read-return tag pipe.
module feature_mem_arbiter
  import cnn_mem_pkg::*;
#(
  parameter int ADDR_W   = cnn_mem_pkg::ADDR_W,
  parameter int DATA_W   = cnn_mem_pkg::DATA_W,
  parameter int N_REQ    = cnn_mem_pkg::N_REQ,
  parameter int MAX_LOCK = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          we,
  input  logic [N_REQ-1:0]          lock,
  input  logic [N_REQ*ADDR_W-1:0]   addr,
  input  logic [N_REQ*DATA_W-1:0]   wdata,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         feature_addr,
  output logic [DATA_W-1:0]         feature_data,
  output logic                      feature_mem_en,
  input  logic [DATA_W-1:0]         feature_idata
);

  localparam int PORT_W = port_w(N_REQ);
  localparam int CNT_W  = $clog2(MAX_LOCK + 1);

  // Handshake: a requester holds req and its payload until the posedge where
  // req[i] & gnt[i]; that edge is the acceptance. rvalid has no back-pressure.

  logic [PORT_W-1:0] last;
  logic [PORT_W-1:0] owner;
  logic              owner_valid;
  logic [CNT_W-1:0]  lock_cnt;

  logic [N_REQ-1:0]  req_masked;
  logic [N_REQ-1:0]  gnt_pick;
  logic              owner_holds;
  logic              accept;
  logic [PORT_W-1:0] acc_port;
  logic [CNT_W-1:0]  next_cnt;
  logic              lock_expire;

  logic              tag1_valid, tag2_valid;
  logic [PORT_W-1:0] tag1_port, tag2_port;

  // A live owner masks every other requester; a dropped owner unmasks at once.
  assign owner_holds = owner_valid && req[owner];

  always_comb begin
    req_masked = req;
    if (owner_holds) begin
      req_masked        = '0;
      req_masked[owner] = 1'b1;
    end
  end

  rr_arbiter #(
    .NUM_REQ (N_REQ),
    .IDX_W   (PORT_W)
  ) u_rr_arbiter (
    .req_masked (req_masked),
    .last       (last),
    .gnt        (gnt_pick)
  );

  assign gnt    = reset ? '0 : gnt_pick;
  assign accept = |(gnt & req);

  always_comb begin
    acc_port = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) acc_port = PORT_W'(i);
    end
  end

  assign next_cnt    = (owner_valid && owner == acc_port) ? lock_cnt + 1'b1 : CNT_W'(1);
  assign lock_expire = (next_cnt == CNT_W'(MAX_LOCK));

  always_ff @(posedge clk) begin
    if (reset) begin
      last           <= PORT_W'(N_REQ - 1);
      owner          <= '0;
      owner_valid    <= 1'b0;
      lock_cnt       <= '0;
      feature_addr   <= '0;
      feature_data   <= '0;
      feature_mem_en <= 1'b0;
      tag1_valid     <= 1'b0;
      tag1_port      <= '0;
      tag2_valid     <= 1'b0;
      tag2_port      <= '0;
      rdata          <= '0;
    end else begin
      feature_mem_en <= 1'b0;
      tag1_valid     <= 1'b0;
      if (accept) begin
        last         <= acc_port;
        feature_addr <= addr[acc_port*ADDR_W +: ADDR_W];
        if (we[acc_port]) begin
          feature_data   <= wdata[acc_port*DATA_W +: DATA_W];
          feature_mem_en <= 1'b1;
        end else begin
          tag1_valid <= 1'b1;
          tag1_port  <= acc_port;
        end
        // The accepting port still becomes 'last' when its lock expires, so
        // the next arbitration favours everyone else.
        if (lock[acc_port] && !lock_expire) begin
          owner       <= acc_port;
          owner_valid <= 1'b1;
          lock_cnt    <= next_cnt;
        end else begin
          owner_valid <= 1'b0;
          lock_cnt    <= '0;
        end
      end else if (owner_valid && !req[owner]) begin
        owner_valid <= 1'b0;
        lock_cnt    <= '0;
      end
      tag2_valid <= tag1_valid;
      tag2_port  <= tag1_port;
      if (tag1_valid) rdata <= feature_idata;
    end
  end

  always_comb begin
    rvalid = '0;
    if (tag2_valid && !reset) rvalid[tag2_port] = 1'b1;
  end

endmodule

// File: tb/tb_feature_mem_arbiter.sv
// Bench for feature_mem_arbiter: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_feature_mem_arbiter;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 32;
  localparam int N_REQ    = 3;
  localparam int MAX_LOCK = 16;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [N_REQ-1:0]        req, we, lock;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ*DATA_W-1:0] wdata;
  logic [N_REQ-1:0]        gnt, rvalid;
  logic [DATA_W-1:0]       rdata;
  logic [ADDR_W-1:0]       feature_addr;
  logic [DATA_W-1:0]       feature_data;
  logic                    feature_mem_en;
  logic [DATA_W-1:0]       feature_idata;

  feature_mem_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .N_REQ    (N_REQ),
    .MAX_LOCK (MAX_LOCK)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .we             (we),
    .lock           (lock),
    .addr           (addr),
    .wdata          (wdata),
    .gnt            (gnt),
    .rvalid         (rvalid),
    .rdata          (rdata),
    .feature_addr   (feature_addr),
    .feature_data   (feature_data),
    .feature_mem_en (feature_mem_en),
    .feature_idata  (feature_idata)
  );

  // ---------------- clock and memory model ----------------
  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem     [4096];
  logic [DATA_W-1:0] ref_mem [4096];

  assign feature_idata = mem[feature_addr];
  always @(posedge clk) if (feature_mem_en) mem[feature_addr] <= feature_data;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acc_log[$];

  typedef struct {
    int                port;
    logic [DATA_W-1:0] data;
    int                due;
  } rd_t;
  rd_t rq[$];

  int                m_last  = N_REQ - 1;
  int                m_owner = -1;
  int                m_cnt   = 0;
  logic [ADDR_W-1:0] m_faddr = '0;
  logic [DATA_W-1:0] m_fdata = '0;
  logic              m_fen   = 1'b0;
  logic [DATA_W-1:0] m_rdata = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- per-cycle model and compare ----------------
  always @(negedge clk) begin : cmp
    int eg;
    int p;
    logic [N_REQ-1:0] exp_gnt, exp_rv;
    eg = -1;
    if (!reset) begin
      if (m_owner >= 0 && req[m_owner]) eg = m_owner;
      else begin
        for (int k = 1; k <= N_REQ; k++) begin
          p = (m_last + k) % N_REQ;
          if (eg < 0 && req[p]) eg = p;
        end
      end
    end
    exp_gnt = '0;
    if (eg >= 0) exp_gnt[eg] = 1'b1;
    exp_rv = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      if (!reset) exp_rv[rq[0].port] = 1'b1;
      void'(rq.pop_front());
    end
    check("gnt", 64'(gnt), 64'(exp_gnt));
    check("rvalid", 64'(rvalid), 64'(exp_rv));
    check("rdata", 64'(rdata), 64'(m_rdata));
    check("feature_addr", 64'(feature_addr), 64'(m_faddr));
    check("feature_data", 64'(feature_data), 64'(m_fdata));
    check("feature_mem_en", 64'(feature_mem_en), 64'(m_fen));

    if (reset) begin
      m_last = N_REQ - 1; m_owner = -1; m_cnt = 0;
      m_faddr = '0; m_fdata = '0; m_fen = 1'b0; m_rdata = '0;
      rq.delete();
    end else begin
      m_fen = 1'b0;
      if (rq.size() > 0 && rq[0].due == cyc + 1) m_rdata = rq[0].data;
      if (eg >= 0) begin
        acc_log.push_back(eg);
        m_last  = eg;
        m_faddr = addr[eg*ADDR_W +: ADDR_W];
        if (we[eg]) begin
          m_fdata = wdata[eg*DATA_W +: DATA_W];
          m_fen   = 1'b1;
          ref_mem[m_faddr] = m_fdata;
        end else begin
          rq.push_back('{eg, ref_mem[m_faddr], cyc + 2});
        end
        if (lock[eg]) begin
          m_cnt = (m_owner == eg) ? m_cnt + 1 : 1;
          if (m_cnt >= MAX_LOCK) begin m_owner = -1; m_cnt = 0; end
          else m_owner = eg;
        end else begin
          m_owner = -1; m_cnt = 0;
        end
      end else if (m_owner >= 0 && !req[m_owner]) begin
        m_owner = -1; m_cnt = 0;
      end
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic r, input logic w, input logic l,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req[p]  = r;
    we[p]   = w;
    lock[p] = l;
    addr[p*ADDR_W +: ADDR_W] = a;
    wdata[p*DATA_W +: DATA_W] = d;
  endtask

  task automatic clear_all();
    req  = '0;
    we   = '0;
    lock = '0;
  endtask

  // ---------------- stimulus ----------------
  int exp_rr[6]    = '{0, 1, 2, 0, 1, 2};
  int en_cnt;
  int got_rd;
  logic [DATA_W-1:0] rd_val;
  logic [N_REQ-1:0]  held;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[12'h010]     = 32'hDEADBEEF;
    ref_mem[12'h010] = 32'hDEADBEEF;
    reset = 1'b1;
    clear_all();
    addr  = '0;
    wdata = '0;
    repeat (3) step();
    reset = 1'b0;

    // Single read with latency 2.
    step();
    set_port(0, 1'b1, 1'b0, 1'b0, 12'h010, 32'h0);
    #1 check("t1_gnt", 64'(gnt), 64'h1);
    step();
    clear_all();
    #1 check("t1_faddr", 64'(feature_addr), 64'h010);
    check("t1_rv_early", 64'(rvalid), 64'h0);
    step();
    #1 check("t1_rvalid", 64'(rvalid), 64'h1);
    check("t1_rdata", 64'(rdata), 64'hDEADBEEF);
    step();
    #1 check("t1_rv_late", 64'(rvalid), 64'h0);

    // Reset in the cycle after a read acceptance.
    step();
    set_port(0, 1'b1, 1'b0, 1'b0, 12'h020, 32'h0);
    step();
    clear_all();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1 check("t5_rvalid", 64'(rvalid), 64'h0);
    check("t5_faddr", 64'(feature_addr), 64'h0);
    check("t5_rdata", 64'(rdata), 64'h0);
    check("t5_en", 64'(feature_mem_en), 64'h0);

    // All ports reading continuously without lock.
    step();
    for (int p = 0; p < N_REQ; p++) set_port(p, 1'b1, 1'b0, 1'b0, 12'(p + 1), 32'h0);
    acc_log.delete();
    repeat (6) step();
    clear_all();
    check("t2_count", 64'(acc_log.size()), 64'd6);
    for (int i = 0; i < 6; i++) check("t2_order", 64'(acc_log[i]), 64'(exp_rr[i]));
    repeat (3) step();

    // Write then read-after-write on the next beat.
    set_port(2, 1'b1, 1'b1, 1'b0, 12'h005, 32'h12345678);
    en_cnt = 0; got_rd = 0; rd_val = '0;
    step();
    req[2] = 1'b0;
    set_port(1, 1'b1, 1'b0, 1'b0, 12'h005, 32'h0);
    #1 en_cnt += int'(feature_mem_en);
    step();
    req[1] = 1'b0;
    #1 en_cnt += int'(feature_mem_en);
    for (int i = 0; i < 4; i++) begin
      step();
      #1 en_cnt += int'(feature_mem_en);
      if (rvalid[1]) begin got_rd++; rd_val = rdata; end
    end
    check("t3_en_cycles", 64'(en_cnt), 64'd1);
    check("t3_rv_count", 64'(got_rd), 64'd1);
    check("t3_rdata", 64'(rd_val), 64'h12345678);

    // Bounded lock: port 1 locked, port 0 competing.
    step();
    set_port(1, 1'b1, 1'b0, 1'b1, 12'h003, 32'h0);
    acc_log.delete();
    step();
    set_port(0, 1'b1, 1'b0, 1'b0, 12'h007, 32'h0);
    repeat (17) step();
    clear_all();
    check("t4_count", 64'(acc_log.size()), 64'd18);
    for (int i = 0; i < 18; i++)
      check("t4_order", 64'(acc_log[i]), (i == 16) ? 64'd0 : 64'd1);
    repeat (3) step();

    // Owner drops req: a waiting port is granted in the same cycle.
    set_port(1, 1'b1, 1'b0, 1'b1, 12'h009, 32'h0);
    step();
    set_port(2, 1'b1, 1'b0, 1'b0, 12'h00A, 32'h0);
    #1 check("t6_locked_gnt", 64'(gnt), 64'h2);
    step();
    req[1] = 1'b0;
    #1 check("t6_release_gnt", 64'(gnt), 64'h4);
    step();
    clear_all();
    repeat (3) step();

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      #1 held = req & gnt;
      step();
      reset = ($urandom_range(0, 99) == 0);
      for (int p = 0; p < N_REQ; p++) begin
        if (!req[p] || held[p]) begin
          if ($urandom_range(0, 1) == 1)
            set_port(p, 1'b1, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                     12'($urandom_range(0, 15)), $urandom);
          else
            req[p] = 1'b0;
        end else if ($urandom_range(0, 19) == 0) begin
          req[p] = 1'b0;
        end
      end
    end
    reset = 1'b0;
    clear_all();
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
